// File: rtl/mdu_hilo.sv
`default_nettype none
// ============================================================================
// Module      : mdu_hilo
// Description : Iterative multiply/divide unit with the HI/LO register pair.
//               Define MDU_FAST_MUL_EN for a single-cycle array multiplier.
// Revision    : 1.0 - initial release
// ============================================================================
module mdu_hilo (
  input  logic        clk,
  input  logic        resetn,
  input  logic        in_valid,
  input  logic [1:0]  MULT,
  input  logic [1:0]  DIV,
  input  logic [1:0]  MFHL,
  input  logic [1:0]  MTHL,
  input  logic [31:0] rs_value,
  input  logic [31:0] rt_value,
  output logic        mdu_stall,
  output logic [31:0] hilo_rdata,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_FIX  = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [4:0]  r_cnt;
  logic [4:0]  w_cnt_nxt;

  logic [31:0] r_hi;
  logic [31:0] r_lo;
  // Working registers: acc_hi is partial product / partial remainder,
  // acc_lo is multiplier / dividend-then-quotient, opnd is multiplicand / divisor.
  logic [31:0] r_acc_hi;
  logic [31:0] r_acc_lo;
  logic [31:0] r_opnd;
  logic        r_is_div;
  logic        r_neg_q;
  logic        r_neg_r;
  logic        r_div0;
  logic        r_done;

  logic        w_any;
  logic        w_busy;
  logic        w_accept;
  logic        w_start_mul;
  logic        w_start_div;
  logic        w_signed;
  logic        w_rs_neg;
  logic        w_rt_neg;
  logic [31:0] w_rs_mag;
  logic [31:0] w_rt_mag;
  logic [32:0] w_shift;
  logic [32:0] w_trial;
  logic [63:0] w_prod;
  logic [63:0] w_prod_fix;
  logic [31:0] w_quo;
  logic [31:0] w_rem;
`ifndef MDU_FAST_MUL_EN
  logic [32:0] w_add;
`endif

  assign w_any       = |{MULT, DIV, MFHL, MTHL};
  assign w_busy      = (r_state != S_IDLE);
  assign w_accept    = in_valid & w_any & ~w_busy;
  assign w_start_mul = w_accept & (|MULT);
  assign w_start_div = w_accept & (|DIV);

  assign w_signed = MULT[0] | DIV[0];
  assign w_rs_neg = w_signed & rs_value[31];
  assign w_rt_neg = w_signed & rt_value[31];
  assign w_rs_mag = w_rs_neg ? (-rs_value) : rs_value;
  assign w_rt_mag = w_rt_neg ? (-rt_value) : rt_value;

  // Restoring divide step: shift in the next dividend bit, try subtracting.
  assign w_shift = {r_acc_hi, r_acc_lo[31]};
  assign w_trial = w_shift - {1'b0, r_opnd};

`ifndef MDU_FAST_MUL_EN
  assign w_add = {1'b0, r_acc_hi} + (r_acc_lo[0] ? {1'b0, r_opnd} : 33'd0);
`endif

  assign w_prod     = {r_acc_hi, r_acc_lo};
  assign w_prod_fix = r_neg_q ? (-w_prod) : w_prod;
  // Divide by zero leaves |rs| as remainder, so sign restoration yields rs itself.
  assign w_quo      = r_div0 ? 32'hFFFF_FFFF : (r_neg_q ? (-r_acc_lo) : r_acc_lo);
  assign w_rem      = r_neg_r ? (-r_acc_hi) : r_acc_hi;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (w_start_mul) begin
          w_state_nxt = S_MUL;
        end else if (w_start_div) begin
          w_state_nxt = S_DIV;
        end
      end
      S_MUL: begin
`ifdef MDU_FAST_MUL_EN
        w_state_nxt = S_FIX;
`else
        w_cnt_nxt = r_cnt + 5'd1;
        if (r_cnt == 5'd31) begin
          w_state_nxt = S_FIX;
        end
`endif
      end
      S_DIV: begin
        w_cnt_nxt = r_cnt + 5'd1;
        if (r_cnt == 5'd31) begin
          w_state_nxt = S_FIX;
        end
      end
      S_FIX: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= S_IDLE;
      r_cnt   <= 5'd0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_done  <= (r_state == S_FIX);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_hi     <= 32'd0;
      r_lo     <= 32'd0;
      r_acc_hi <= 32'd0;
      r_acc_lo <= 32'd0;
      r_opnd   <= 32'd0;
      r_is_div <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_div0   <= 1'b0;
    end else begin
      if (w_accept & MTHL[1]) begin
        r_hi <= rs_value;
      end
      if (w_accept & MTHL[0]) begin
        r_lo <= rs_value;
      end

      case (r_state)
        S_IDLE: begin
          if (w_start_mul) begin
            r_acc_hi <= 32'd0;
            r_acc_lo <= w_rt_mag;
            r_opnd   <= w_rs_mag;
            r_is_div <= 1'b0;
            r_neg_q  <= w_rs_neg ^ w_rt_neg;
            r_neg_r  <= 1'b0;
            r_div0   <= 1'b0;
          end else if (w_start_div) begin
            r_acc_hi <= 32'd0;
            r_acc_lo <= w_rs_mag;
            r_opnd   <= w_rt_mag;
            r_is_div <= 1'b1;
            r_neg_q  <= w_rs_neg ^ w_rt_neg;
            r_neg_r  <= w_rs_neg;
            r_div0   <= (rt_value == 32'd0);
          end
        end
        S_MUL: begin
`ifdef MDU_FAST_MUL_EN
          {r_acc_hi, r_acc_lo} <= {32'd0, r_opnd} * {32'd0, r_acc_lo};
`else
          r_acc_hi <= w_add[32:1];
          r_acc_lo <= {w_add[0], r_acc_lo[31:1]};
`endif
        end
        S_DIV: begin
          if (!w_trial[32]) begin
            r_acc_hi <= w_trial[31:0];
            r_acc_lo <= {r_acc_lo[30:0], 1'b1};
          end else begin
            r_acc_hi <= w_shift[31:0];
            r_acc_lo <= {r_acc_lo[30:0], 1'b0};
          end
        end
        S_FIX: begin
          if (r_is_div) begin
            r_hi <= w_rem;
            r_lo <= w_quo;
          end else begin
            r_hi <= w_prod_fix[63:32];
            r_lo <= w_prod_fix[31:0];
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign busy       = w_busy;
  assign done       = r_done;
  assign mdu_stall  = in_valid & w_busy & w_any;
  assign hilo_rdata = (in_valid & (|MFHL)) ? (MFHL[1] ? r_hi : r_lo) : 32'd0;

endmodule
`default_nettype wire
